// File: rtl/flash_read_ctrl.sv
// flash_read_ctrl: serial-flash READ sequencer.
// Drives chip select, sends the command byte plus a 24-bit address through
// the byte transmitter, then requests one byte at a time from the byte
// receiver and streams each received byte out with a valid strobe.
// Handshake outputs are registered decodes of the current state, so each
// appears one cycle after its state is entered.
module flash_read_ctrl #(
  parameter logic [7:0]  CMD_READ = 8'h03,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [8:0]  len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        spi_cs_n,
  output logic        en_tx,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        en_rx,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic [7:0]  dout,
  output logic        dout_valid
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_TX_ISSUE = 3'd2;
  localparam logic [2:0] S_TX_WAIT  = 3'd3;
  localparam logic [2:0] S_RX_ISSUE = 3'd4;
  localparam logic [2:0] S_RX_WAIT  = 3'd5;
  localparam logic [2:0] S_HOLD     = 3'd6;
  localparam logic [2:0] S_FIN      = 3'd7;

  // Terminal counts: each counter starts at zero, so N cycles end at N-1.
  localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);
  localparam logic [9:0] WAIT_LAST  = 10'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [23:0] addr_q;
  logic [8:0]  rem;
  logic [1:0]  byte_idx;
  logic [3:0]  cs_cnt;
  logic [9:0]  wait_cnt;
  logic        timed_out;
  logic [7:0]  tx_byte;

  // Header byte selected by the transmit index: command, then address MSB first.
  always_comb begin
    tx_byte = CMD_READ;
    case (byte_idx)
      2'd0:    tx_byte = CMD_READ;
      2'd1:    tx_byte = addr_q[23:16];
      2'd2:    tx_byte = addr_q[15:8];
      default: tx_byte = addr_q[7:0];
    endcase
  end

  // Transaction sequencer: state, byte index, remaining count and timers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      rem       <= '0;
      byte_idx  <= '0;
      cs_cnt    <= '0;
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q    <= addr;
            rem       <= len;
            byte_idx  <= '0;
            cs_cnt    <= '0;
            timed_out <= 1'b0;
            // A zero-length read completes without ever touching the bus.
            state     <= (len == 9'd0) ? S_FIN : S_SETUP;
          end
        end
        S_SETUP: begin
          if (cs_cnt == SETUP_LAST) begin
            cs_cnt <= '0;
            state  <= S_TX_ISSUE;
          end else begin
            cs_cnt <= cs_cnt + 4'd1;
          end
        end
        S_TX_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (tx_done) begin
            byte_idx <= byte_idx + 2'd1;
            state    <= (byte_idx == 2'd3) ? S_RX_ISSUE : S_TX_ISSUE;
          end else if (wait_cnt == WAIT_LAST) begin
            timed_out <= 1'b1;
            state     <= S_FIN;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        S_RX_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_RX_WAIT;
        end
        S_RX_WAIT: begin
          if (rx_done) begin
            rem <= rem - 9'd1;
            if (rem == 9'd1) begin
              cs_cnt <= '0;
              state  <= S_HOLD;
            end else begin
              state <= S_RX_ISSUE;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            timed_out <= 1'b1;
            state     <= S_FIN;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        S_HOLD: begin
          if (cs_cnt == HOLD_LAST) begin
            state <= S_FIN;
          end else begin
            cs_cnt <= cs_cnt + 4'd1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered status, chip select and engine strobes decoded from state.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      spi_cs_n <= 1'b1;
      en_tx    <= 1'b0;
      tx_data  <= '0;
      en_rx    <= 1'b0;
    end else begin
      busy     <= (state != S_IDLE);
      done     <= (state == S_FIN);
      err      <= (state == S_FIN) && timed_out;
      spi_cs_n <= (state == S_IDLE) || (state == S_FIN);
      en_tx    <= (state == S_TX_ISSUE);
      en_rx    <= (state == S_RX_ISSUE);
      // tx_data only changes when a new byte is issued, so it stays stable
      // for the whole transmit.
      if (state == S_TX_ISSUE) begin
        tx_data <= tx_byte;
      end
    end
  end

  // Received-byte capture: only an expected rx_done produces a strobe.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= (state == S_RX_WAIT) && rx_done;
      if ((state == S_RX_WAIT) && rx_done) begin
        dout <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_flash_read_ctrl.sv
// tb_flash_read_ctrl: table-driven bench for flash_read_ctrl with SPI byte
// engine responder stubs and a queue scoreboard for tx bytes and rx bytes.
module tb_flash_read_ctrl;

  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int TIMEOUT  = 255;
  localparam int RESP_DLY = 80;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start;
  logic [23:0] addr;
  logic [8:0]  len;
  logic        busy, done, err, spi_cs_n, en_tx, en_rx, dout_valid;
  logic [7:0]  tx_data, dout;
  logic        tx_done = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  flash_read_ctrl #(
    .CMD_READ (8'h03),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .addr       (addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .spi_cs_n   (spi_cs_n),
    .en_tx      (en_tx),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .en_rx      (en_rx),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [23:0] addr;
    int          len;
    logic [7:0]  rx_base;
    int          withhold;   // tx byte index left unanswered, -1 for none
    int          exp_ntx;
    int          exp_nrx;
    int          exp_nvalid;
    logic        exp_err;
    int          exp_csfall;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  string tag = "init";

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  // Written only by the negedge monitor/responder process.
  int cyc = 0;
  int n_tx = 0, n_rx = 0, n_rxd = 0, n_valid = 0, done_cnt = 0, n_csfall = 0;
  int t_done = 0, t_cs_low = 0, t_tx_first = 0, t_tx_last = 0, t_rx_last = 0;
  int t_busy_fall = 0, tx_since_cs = 0, tx_tmr = 0, rx_tmr = 0;
  logic err_at_done = 1'b0, cs_at_done = 1'b0;
  logic prev_cs = 1'b1, prev_busy = 1'b0;

  // Written only by the driver (initial block).
  int tx0 = 0, rx0 = 0, rxd0 = 0, val0 = 0, done0 = 0, fall0 = 0, t_start = 0;
  int withhold = -1;
  logic [7:0] rx_base = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  // Monitor and responder stubs, evaluated on the inactive edge.
  always @(negedge sys_clk) begin
    cyc++;
    if (prev_cs && !spi_cs_n) begin
      n_csfall++;
      t_cs_low    = cyc;
      tx_since_cs = 0;
    end
    if (en_tx) begin
      n_tx++;
      t_tx_last = cyc;
      if (tx_since_cs == 0) t_tx_first = cyc;
      tx_since_cs++;
      if (txq.size() == 0) check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
      else check("tx_data", 32'(tx_data), 32'(txq.pop_front()));
    end
    if (en_rx) n_rx++;
    if (dout_valid) begin
      n_valid++;
      if (rxq.size() == 0) check("dout_unexpected", 32'(dout), 32'hFFFF_FFFF);
      else check("dout", 32'(dout), 32'(rxq.pop_front()));
    end
    if (done) begin
      done_cnt++;
      t_done      = cyc;
      err_at_done = err;
      cs_at_done  = spi_cs_n;
    end
    if (prev_busy && !busy) t_busy_fall = cyc;
    prev_cs   = spi_cs_n;
    prev_busy = busy;

    tx_done = 1'b0;
    rx_done = 1'b0;
    if (tx_tmr != 0) begin
      tx_tmr--;
      if (tx_tmr == 0) tx_done = 1'b1;
    end
    if (rx_tmr != 0) begin
      rx_tmr--;
      if (rx_tmr == 0) begin
        rx_done = 1'b1;
        rx_data = rx_base + 8'(n_rxd - rxd0);
        rxq.push_back(rx_data);
        n_rxd++;
        t_rx_last = cyc;
      end
    end
    if (en_tx && ((n_tx - tx0 - 1) != withhold)) tx_tmr = RESP_DLY;
    if (en_rx) rx_tmr = RESP_DLY;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_done"}, 32'(done), 0);
    check({pfx, "_err"}, 32'(err), 0);
    check({pfx, "_cs_n"}, 32'(spi_cs_n), 1);
    check({pfx, "_en_tx"}, 32'(en_tx), 0);
    check({pfx, "_tx_data"}, 32'(tx_data), 0);
    check({pfx, "_en_rx"}, 32'(en_rx), 0);
    check({pfx, "_dout"}, 32'(dout), 0);
    check({pfx, "_dout_valid"}, 32'(dout_valid), 0);
  endtask

  task automatic start_vec(input vec_t v);
    txq.delete();
    rxq.delete();
    if (v.len != 0) begin
      txq.push_back(8'h03);
      txq.push_back(v.addr[23:16]);
      txq.push_back(v.addr[15:8]);
      txq.push_back(v.addr[7:0]);
    end
    tx0 = n_tx; rx0 = n_rx; rxd0 = n_rxd; val0 = n_valid;
    done0 = done_cnt; fall0 = n_csfall;
    withhold = v.withhold;
    rx_base  = v.rx_base;
    addr     = v.addr;
    len      = 9'(v.len);
    start    = 1'b1;
    t_start  = cyc;
    wait_cycles(1);
    start = 1'b0;
  endtask

  task automatic finish_vec(input vec_t v);
    int budget;
    budget = (v.len + 5) * (RESP_DLY + 10) + TIMEOUT + 200;
    for (int i = 0; i < budget && done_cnt == done0; i++) wait_cycles(1);
    check("done_count", 32'(done_cnt - done0), 1);
    wait_cycles(3);
    check("n_en_tx", 32'(n_tx - tx0), 32'(v.exp_ntx));
    check("n_en_rx", 32'(n_rx - rx0), 32'(v.exp_nrx));
    check("n_dout_valid", 32'(n_valid - val0), 32'(v.exp_nvalid));
    check("rx_left", 32'(rxq.size()), 0);
    check("err_at_done", 32'(err_at_done), 32'(v.exp_err));
    check("cs_high_at_done", 32'(cs_at_done), 1);
    // One falling edge of spi_cs_n means it stayed low for the whole transfer.
    check("cs_falls", 32'(n_csfall - fall0), 32'(v.exp_csfall));
    check("busy_fall_after_fin", 32'(t_busy_fall - t_done), 1);
    if (v.len == 0) begin
      // start sampled at the next edge, FIN decoded on the edge after.
      check("len0_done_latency", 32'(t_done - t_start), 2);
    end else begin
      check("cs_low_latency", 32'(t_cs_low - t_start), 2);
      check("cs_setup_cycles", 32'(t_tx_first - t_cs_low), 32'(CS_SETUP));
      if (v.exp_err) begin
        // TIMEOUT wait cycles, then the FIN cycle, then done is visible.
        check("timeout_latency", 32'(t_done - t_tx_last), 32'(TIMEOUT + 1));
      end else begin
        // rx_done driven here is sampled at the next edge; done follows
        // CS_HOLD+1 edges later, seen on the following inactive edge.
        check("hold_latency", 32'(t_done - t_rx_last), 32'(CS_HOLD + 2));
      end
    end
  endtask

  vec_t vecs[5];
  vec_t v_ign, v_rst, v_post;

  initial begin
    vecs[0] = '{24'h123456,   1, 8'hA5, -1, 4,   1,   1, 1'b0, 1};
    vecs[1] = '{24'hABCDEF, 256, 8'h00, -1, 4, 256, 256, 1'b0, 1};
    vecs[2] = '{24'h654321,   0, 8'h00, -1, 0,   0,   0, 1'b0, 0};
    vecs[3] = '{24'h00F00D,   3, 8'h11,  2, 3,   0,   0, 1'b1, 1};
    vecs[4] = '{24'hFEDCBA,   3, 8'h7E, -1, 4,   3,   3, 1'b0, 1};
    v_ign   = '{24'h2468AC,   4, 8'h30, -1, 4,   4,   4, 1'b0, 1};
    v_rst   = '{24'h13579B,   8, 8'h5A, -1, 4,   8,   8, 1'b0, 1};
    v_post  = '{24'h0A0B0C,   2, 8'hF0, -1, 4,   2,   2, 1'b0, 1};

    sys_rst_n = 1'b0;
    start     = 1'b0;
    addr      = '0;
    len       = '0;
    wait_cycles(3);
    tag = "reset";
    check_reset_outputs("rst");
    sys_rst_n = 1'b1;
    wait_cycles(2);

    for (int k = 0; k < 5; k++) begin
      tag = $sformatf("vec%0d", k);
      start_vec(vecs[k]);
      finish_vec(vecs[k]);
      wait_cycles(2);
    end

    // start pulsed while a receive is outstanding must not disturb anything.
    tag = "ignore_start";
    start_vec(v_ign);
    for (int i = 0; i < 2000 && (n_rx - rx0) < 2; i++) wait_cycles(1);
    check("reached_rx", 32'((n_rx - rx0) >= 2), 1);
    wait_cycles(5);
    addr  = 24'h777777;
    len   = 9'd9;
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    finish_vec(v_ign);
    wait_cycles(10);
    check("idle_after", 32'(busy), 0);

    // One-cycle reset in the middle of the receive phase.
    tag = "mid_reset";
    start_vec(v_rst);
    for (int i = 0; i < 3000 && (n_valid - val0) < 3; i++) wait_cycles(1);
    check("reached_3_bytes", 32'((n_valid - val0) >= 3), 1);
    sys_rst_n = 1'b0;
    wait_cycles(1);
    check_reset_outputs("mid");
    sys_rst_n = 1'b1;
    begin
      int tx_snap, val_snap;
      tx_snap  = n_tx;
      val_snap = n_valid;
      wait_cycles(300);
      check("no_done", 32'(done_cnt - done0), 0);
      check("no_more_tx", 32'(n_tx - tx_snap), 0);
      check("no_more_valid", 32'(n_valid - val_snap), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_cs_n", 32'(spi_cs_n), 1);
    end

    tag = "post_reset";
    start_vec(v_post);
    finish_vec(v_post);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
